// File: rtl/pd_exec_pkg.sv
// Shared encodings for the pd execute stage: opcodes, funct fields, ALU op and
// multiplier FSM state enums.
package pd_exec_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_MUL  = 3'b000;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE, MUL_BUSY, MUL_DONE
    } mul_state_e;

endpackage

// File: rtl/pd_iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DWIDTH cycles,
// low DWIDTH bits of the product.
module pd_iter_mul
    import pd_exec_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DWIDTH-1:0] i_a,
    input  logic [DWIDTH-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DWIDTH-1:0] o_product
);

    localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    logic [DWIDTH-1:0] r_acc;
    logic [DWIDTH-1:0] r_mcand;
    logic [DWIDTH-1:0] r_mplier;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= CW'(DWIDTH - 1);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

    // done flags the cycle whose closing edge retires the final bit
    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_cnt == '0);
    assign o_product = r_acc;

endmodule

// File: rtl/pd_execute_pipe.sv
// Registered execute stage: ALU, branch and jump evaluation into a valid/ready
// output register. Define PD_MUL_EN to add the iterative R-type MUL unit.
module pd_execute_pipe
    import pd_exec_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AWIDTH-1:0] in_pc,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [DWIDTH-1:0] in_rs1_data,
    input  logic [DWIDTH-1:0] in_rs2_data,
    input  logic [DWIDTH-1:0] in_imm,
    input  logic              flush,
    input  logic              out_ready,
    output logic              e_valid,
    output logic [AWIDTH-1:0] e_pc,
    output logic [DWIDTH-1:0] e_res,
    output logic              e_brtaken,
    output logic [AWIDTH-1:0] e_link,
    output logic [4:0]        e_rd,
    output logic              e_illegal
);

    logic              r_valid, r_br, r_ill;
    logic [AWIDTH-1:0] r_pc, r_link;
    logic [DWIDTH-1:0] r_res;
    logic [4:0]        r_rd;

    logic              w_busy, w_accept, w_load, w_mul_load, w_is_mul;
    logic              w_is_r, w_r_legal, w_br_legal, w_taken;
    logic              w_res_br, w_res_ill;
    logic [4:0]        w_shamt;
    logic [DWIDTH-1:0] w_opb, w_alu_res, w_addr, w_res;
    logic [AWIDTH-1:0] w_pc_tgt, w_pc_lnk, w_res_link;
    alu_op_e           w_alu_op;

    logic              w_nxt_br, w_nxt_ill;
    logic [DWIDTH-1:0] w_nxt_res;
    logic [AWIDTH-1:0] w_nxt_pc, w_nxt_link;
    logic [4:0]        w_nxt_rd;

    assign in_ready = ~flush & ~w_busy & (~r_valid | out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_load   = (w_accept & ~w_is_mul) | w_mul_load;

    assign w_is_r   = (in_opcode == OP_R);
    assign w_opb    = w_is_r ? in_rs2_data : in_imm;
    assign w_shamt  = w_opb[4:0];
    assign w_addr   = in_rs1_data + in_imm;
    assign w_pc_tgt = in_pc + in_imm[AWIDTH-1:0];
    assign w_pc_lnk = in_pc + AWIDTH'(4);

    assign w_r_legal  = (in_funct7 == F7_BASE) ||
                        ((in_funct7 == F7_ALT) && ((in_funct3 == F3_ADD) || (in_funct3 == F3_SR)));
    assign w_br_legal = (in_funct3 != 3'b010) && (in_funct3 != 3'b011);

    always_comb begin
        w_alu_op = ALU_ADD;
        case (in_funct3)
            F3_ADD:  w_alu_op = (w_is_r && (in_funct7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
            F3_SLL:  w_alu_op = ALU_SLL;
            F3_SLT:  w_alu_op = ALU_SLT;
            F3_SLTU: w_alu_op = ALU_SLTU;
            F3_XOR:  w_alu_op = ALU_XOR;
            F3_SR:   w_alu_op = (in_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            F3_OR:   w_alu_op = ALU_OR;
            default: w_alu_op = ALU_AND;
        endcase
    end

    always_comb begin
        w_alu_res = '0;
        case (w_alu_op)
            ALU_ADD:  w_alu_res = in_rs1_data + w_opb;
            ALU_SUB:  w_alu_res = in_rs1_data - w_opb;
            ALU_SLL:  w_alu_res = in_rs1_data << w_shamt;
            ALU_SLT:  w_alu_res = DWIDTH'($signed(in_rs1_data) < $signed(w_opb));
            ALU_SLTU: w_alu_res = DWIDTH'(in_rs1_data < w_opb);
            ALU_XOR:  w_alu_res = in_rs1_data ^ w_opb;
            ALU_SRL:  w_alu_res = in_rs1_data >> w_shamt;
            ALU_SRA:  w_alu_res = $unsigned($signed(in_rs1_data) >>> w_shamt);
            ALU_OR:   w_alu_res = in_rs1_data | w_opb;
            ALU_AND:  w_alu_res = in_rs1_data & w_opb;
            default:  w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (in_funct3)
            F3_BEQ:  w_taken = (in_rs1_data == in_rs2_data);
            F3_BNE:  w_taken = (in_rs1_data != in_rs2_data);
            F3_BLT:  w_taken = ($signed(in_rs1_data) <  $signed(in_rs2_data));
            F3_BGE:  w_taken = ($signed(in_rs1_data) >= $signed(in_rs2_data));
            F3_BLTU: w_taken = (in_rs1_data <  in_rs2_data);
            F3_BGEU: w_taken = (in_rs1_data >= in_rs2_data);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_res      = '0;
        w_res_br   = 1'b0;
        w_res_link = '0;
        w_res_ill  = 1'b0;
        w_is_mul   = 1'b0;
        case (in_opcode)
            OP_R: begin
                if (in_funct7 == F7_MULDIV) begin
`ifdef PD_MUL_EN
                    if (in_funct3 == F3_MUL) w_is_mul = 1'b1;
                    else                     w_res_ill = 1'b1;
`else
                    w_res_ill = 1'b1;
`endif
                end else if (w_r_legal) begin
                    w_res = w_alu_res;
                end else begin
                    w_res_ill = 1'b1;
                end
            end
            OP_I:              w_res = w_alu_res;
            OP_LOAD, OP_STORE: w_res = w_addr;
            OP_B: begin
                if (w_br_legal) begin
                    w_res    = DWIDTH'(w_pc_tgt);
                    w_res_br = w_taken;
                end else begin
                    w_res_ill = 1'b1;
                end
            end
            OP_JAL: begin
                w_res      = DWIDTH'(w_pc_tgt);
                w_res_br   = 1'b1;
                w_res_link = w_pc_lnk;
            end
            OP_JALR: begin
                w_res      = {w_addr[DWIDTH-1:1], 1'b0};
                w_res_br   = 1'b1;
                w_res_link = w_pc_lnk;
            end
            OP_LUI:   w_res = in_imm;
            OP_AUIPC: w_res = DWIDTH'(w_pc_tgt);
            default:  w_res_ill = 1'b1;
        endcase
    end

`ifdef PD_MUL_EN
    mul_state_e        r_state, w_state_nxt;
    logic              w_mul_start, w_mul_busy, w_mul_done;
    logic [DWIDTH-1:0] w_mul_product;
    logic [AWIDTH-1:0] r_mul_pc;
    logic [4:0]        r_mul_rd;

    assign w_mul_start = w_accept & w_is_mul;

    pd_iter_mul #(.DWIDTH(DWIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_abort   (flush),
        .i_a       (in_rs1_data),
        .i_b       (in_rs2_data),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:     if (w_mul_start) w_state_nxt = MUL_BUSY;
                MUL_BUSY: begin
                    if (w_mul_done)       w_state_nxt = MUL_DONE;
                    else if (!w_mul_busy) w_state_nxt = IDLE;
                end
                MUL_DONE: if (!r_valid || out_ready) w_state_nxt = IDLE;
                default:  w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy     = (r_state != IDLE);
        w_mul_load = (r_state == MUL_DONE) && (!r_valid || out_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_pc <= '0;
            r_mul_rd <= '0;
        end else if (w_mul_start) begin
            r_mul_pc <= in_pc;
            r_mul_rd <= in_rd;
        end
    end
`else
    assign w_busy     = 1'b0;
    assign w_mul_load = 1'b0;
`endif

    always_comb begin
        w_nxt_res  = w_res;
        w_nxt_br   = w_res_br;
        w_nxt_link = w_res_link;
        w_nxt_ill  = w_res_ill;
        w_nxt_pc   = in_pc;
        w_nxt_rd   = in_rd;
`ifdef PD_MUL_EN
        if (w_mul_load) begin
            w_nxt_res  = w_mul_product;
            w_nxt_br   = 1'b0;
            w_nxt_link = '0;
            w_nxt_ill  = 1'b0;
            w_nxt_pc   = r_mul_pc;
            w_nxt_rd   = r_mul_rd;
        end
`endif
    end

    // Flush wins; a load in the same cycle as a consume replaces the result without a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_br    <= 1'b0;
            r_ill   <= 1'b0;
            r_res   <= '0;
            r_pc    <= '0;
            r_link  <= '0;
            r_rd    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_br    <= w_nxt_br;
            r_ill   <= w_nxt_ill;
            r_res   <= w_nxt_res;
            r_pc    <= w_nxt_pc;
            r_link  <= w_nxt_link;
            r_rd    <= w_nxt_rd;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign e_valid   = r_valid;
    assign e_pc      = r_pc;
    assign e_res     = r_res;
    assign e_brtaken = r_br;
    assign e_link    = r_link;
    assign e_rd      = r_rd;
    assign e_illegal = r_ill;

endmodule

// File: doc/pd_execute_pipe.md
# pd_execute_pipe

Registered, parametrised execute stage for the pipelined pd core; sits between the decode and memory pipeline registers. Accepts one decoded instruction per cycle over a valid/ready handshake, computes the ALU result or branch target and branch decision, and holds them in an output pipeline register. Supports backpressure and flush. Optionally includes an iterative multi-cycle multiplier that stalls the stage.

## Interface
- AWIDTH, 32, PC/address width.
- DWIDTH, 32, datapath width; must be ≥ AWIDTH and even.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  AWIDTH  instruction PC.
- in_opcode / in_funct3 / in_funct7  in  7/3/7  decoded fields.
- in_rd  in  5  destination register.
- in_rs1_data / in_rs2_data  in  DWIDTH  operand values, already forwarded.
- in_imm  in  DWIDTH  sign-extended immediate.
- flush  in  1  kill the in-flight and registered instruction.
- out_ready  in  1  memory stage accepts.
- e_valid  out  1  output register holds a live result.
- e_pc  out  AWIDTH  PC of the registered instruction.
- e_res  out  DWIDTH  ALU result, effective address or branch/jump target.
- e_brtaken  out  1  redirect required.
- e_link  out  AWIDTH  pc+4 for JAL/JALR, else 0.
- e_rd  out  5  destination register.
- e_illegal  out  1  unsupported opcode/funct combination.

## Operation
- Accept condition: in_valid & in_ready. in_ready = ~flush & ~busy & (~e_valid | out_ready).
- R/I-type: ADD, SUB (R only, funct7 0100000), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is operand[4:0]. I-type ignores funct7 except SRAI.
- Branches: e_res = pc+imm. e_brtaken follows BEQ/BNE/BLT/BGE (signed) and BLTU/BGEU (unsigned).
- JAL: e_res = pc+imm. JALR: e_res = (rs1+imm) & ~1. Both set e_brtaken=1 and e_link=pc+4.
- LUI: e_res = imm. AUIPC: e_res = pc+imm. LOAD/STORE: e_res = rs1+imm.
- Any other opcode/funct: e_illegal=1, e_res=0, e_brtaken=0.
- All arithmetic is modulo 2^DWIDTH. PC arithmetic is modulo 2^AWIDTH and zero-extended into e_res.

## Timing
- Reset: e_valid, e_brtaken, e_illegal = 0; e_res, e_pc, e_link = 0; e_rd = 0; FSM in IDLE; in_ready = 1 once reset deasserts.
- Latency 1: an instruction accepted at edge N is visible on the outputs after edge N and until it is consumed.
- Output register holds its value while e_valid & ~out_ready.
- Simultaneous consume and accept: the new result replaces the old one with no bubble.
- flush: e_valid=0 after the next edge. An instruction presented in the flush cycle is not accepted. Any multiply in progress is aborted and the FSM returns to IDLE.
- Reset mid-operation: immediate return to reset values.

## Configuration
- PD_MUL_EN defined: R-type funct7 0000001, funct3 000 (MUL) is executed by a shift-add multiplier that retires 1 bit per cycle.
  - FSM: IDLE → MUL_BUSY (DWIDTH cycles, busy=1) → MUL_DONE (loads the output register when ~e_valid | out_ready, else waits) → IDLE.
  - Accept-to-e_valid latency: DWIDTH+1 cycles.
  - e_res = low DWIDTH bits of the product, signed or unsigned (identical).
  - Other M funct3 values: e_illegal.
- PD_MUL_EN undefined: all funct7 0000001 ops are e_illegal, busy is tied to 0, and no multiplier logic is present.

## Structure
- Package pd_exec_pkg holds:
  - opcode localparams (R, I, LOAD, STORE, B, JAL, JALR, LUI, AUIPC);
  - funct3/funct7 constants;
  - alu_op_e enum;
  - mul_state_e enum {IDLE, MUL_BUSY, MUL_DONE}.
- Sub-module pd_iter_mul, parametrised by DWIDTH, with start/abort/busy/done/product ports. Instantiated only under PD_MUL_EN.

## Test plan
- ADDI with rs1=0, imm=150, then rs1=0, imm=-50 → e_res=150, then 0xFFFFFFCE; e_valid one cycle after each accept.
- ADD and SUB with rs1=100, rs2=150 → 250, then 0xFFFFFFCE.
- BNE rs1=100, rs2=150, pc=0x01000000, imm=16 → e_res=0x01000010, brtaken=1. BEQ, same operands, imm=-16 → e_res=0x00FFFFF0, brtaken=0.
- Hold out_ready=0 for 3 cycles with e_valid=1 → in_ready=0, outputs stable. Release while a new in_valid is present → back-to-back update with no bubble.
- JALR rs1=0x1003, imm=4, pc=0x200 → e_res=0x1006, e_link=0x204, brtaken=1. Unknown opcode 0x7F → e_illegal=1.
- PD_MUL_EN: MUL 7 × 0xFFFFFFFD → e_res=0xFFFFFFEB after 33 cycles, in_ready=0 throughout. Second run with flush at cycle 10 → e_valid stays 0 and in_ready=1 the next cycle.
